// File: rtl/mb_pkg.sv
// rtl/mb_pkg.sv - shared states, status codes and field widths for the PIN sequencer
package mb_pkg;

    localparam int PIN_W = 5;
    localparam int COD_W = 6;
    localparam int VAL_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASK_PIN,
        S_CHECK,
        S_BAD,
        S_ASK_VAL,
        S_AUTH,
        S_DONE,
        S_LOCKED
    } state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ASK_PIN  = 3'd1;
    localparam logic [2:0] ST_ASK_VAL  = 3'd2;
    localparam logic [2:0] ST_BUSY     = 3'd3;
    localparam logic [2:0] ST_OK       = 3'd4;
    localparam logic [2:0] ST_BAD_PIN  = 3'd5;
    localparam logic [2:0] ST_NO_FUNDS = 3'd6;
    localparam logic [2:0] ST_LOCKED   = 3'd7;

endpackage

// File: rtl/mb_pin_sequencer_if.sv
// rtl/mb_pin_sequencer_if.sv - card reader / keypad inputs and authorisation-stage outputs
interface mb_pin_sequencer_if;

    logic                      card;
    logic [mb_pkg::COD_W-1:0]  cod;
    logic [mb_pkg::VAL_W-1:0]  saldo;
    logic                      key_vld;
    logic [mb_pkg::PIN_W-1:0]  key_data;
    logic                      cancel;

    logic                      en;
    logic [mb_pkg::PIN_W-1:0]  pin;
    logic [mb_pkg::COD_W-1:0]  cod_out;
    logic [mb_pkg::VAL_W-1:0]  val;
    logic [mb_pkg::VAL_W-1:0]  saldo_out;
    logic [2:0]                status;
    logic                      dispense;

    modport slave (
        input  card, cod, saldo, key_vld, key_data, cancel,
        output en, pin, cod_out, val, saldo_out, status, dispense
    );

    modport master (
        output card, cod, saldo, key_vld, key_data, cancel,
        input  en, pin, cod_out, val, saldo_out, status, dispense
    );

endinterface

// File: rtl/mb_edge_det.sv
// rtl/mb_edge_det.sv - registered rise/fall detector for the card-present level
module mb_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            lvl  <= din;
            rise <= din & ~lvl;
            fall <= ~din & lvl;
        end
    end

endmodule

// File: rtl/mb_pin_sequencer.sv
// rtl/mb_pin_sequencer.sv - card/PIN/value sequencer ahead of authorisation; MB_TIMEOUT_EN adds an idle abort
module mb_pin_sequencer
    import mb_pkg::*;
#(
    parameter int MAX_TRIES = 3
`ifdef MB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    mb_pin_sequencer_if.slave  bus
);

    state_t             state_q, state_d;
    logic               card_lvl, card_rise, card_fall;
    logic [2:0]         tries_q;
    logic               lock_q;
    logic [COD_W-1:0]   locked_cod_q;
    logic               auth_cnt_q;
    logic [PIN_W-1:0]   pin_q;
    logic [COD_W-1:0]   cod_out_q;
    logic [VAL_W-1:0]   val_q;
    logic [VAL_W-1:0]   saldo_q;
    logic [2:0]         status_q, status_d;
    logic               en_q, en_d;
    logic               dispense_q, dispense_d;
    logic               abort, tmo_hit, pin_ok, funds_ok, lock_hit, tries_max;

    mb_edge_det u_card_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.card),
        .lvl   (card_lvl),
        .rise  (card_rise),
        .fall  (card_fall)
    );

`ifdef MB_TIMEOUT_EN
    logic [10:0] tmo_cnt_q;
    assign tmo_hit = (tmo_cnt_q == 11'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt_q <= '0;
        else if ((state_q == S_ASK_PIN || state_q == S_ASK_VAL) && state_d == state_q && !bus.key_vld)
            tmo_cnt_q <= tmo_cnt_q + 11'd1;
        else
            tmo_cnt_q <= '0;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign abort     = bus.cancel | card_fall;
    assign pin_ok    = ({1'b0, pin_q} == cod_out_q);
    assign funds_ok  = (val_q <= saldo_q);
    assign lock_hit  = lock_q && (bus.cod == locked_cod_q);
    assign tries_max = (tries_q == 3'(MAX_TRIES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (card_rise) state_d = lock_hit ? S_LOCKED : S_ASK_PIN;
            S_ASK_PIN: if (abort || tmo_hit) state_d = S_IDLE;
                       else if (bus.key_vld) state_d = S_CHECK;
            S_CHECK:   if (abort) state_d = S_IDLE;
                       else state_d = pin_ok ? S_ASK_VAL : S_BAD;
            // Lock-out wins over a simultaneous abort so the code is never left unlocked.
            S_BAD:     if (tries_max) state_d = S_LOCKED;
                       else if (abort) state_d = S_IDLE;
                       else state_d = S_ASK_PIN;
            S_ASK_VAL: if (abort || tmo_hit) state_d = S_IDLE;
                       else if (bus.key_vld && bus.key_data != '0) state_d = S_AUTH;
            S_AUTH:    if (abort) state_d = S_IDLE;
                       else if (auth_cnt_q) state_d = S_DONE;
            S_DONE:    if (!card_lvl) state_d = S_IDLE;
            S_LOCKED:  if (!card_lvl) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        en_d       = (state_d != S_AUTH);
        dispense_d = (state_q == S_AUTH) && (state_d == S_DONE) && funds_ok;
        status_d   = ST_IDLE;
        case (state_d)
            S_IDLE:    status_d = ST_IDLE;
            S_ASK_PIN: status_d = ST_ASK_PIN;
            S_CHECK:   status_d = ST_BUSY;
            S_BAD:     status_d = ST_BAD_PIN;
            S_ASK_VAL: status_d = ST_ASK_VAL;
            S_AUTH:    status_d = ST_BUSY;
            S_DONE:    status_d = (state_q == S_DONE) ? status_q
                                : (funds_ok ? ST_OK : ST_NO_FUNDS);
            S_LOCKED:  status_d = ST_LOCKED;
            default:   status_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tries_q      <= '0;
            lock_q       <= 1'b0;
            locked_cod_q <= '0;
            auth_cnt_q   <= 1'b0;
            pin_q        <= '0;
            cod_out_q    <= '0;
            val_q        <= '0;
            saldo_q      <= '0;
            status_q     <= ST_IDLE;
            en_q         <= 1'b1;
            dispense_q   <= 1'b0;
        end else begin
            status_q   <= status_d;
            en_q       <= en_d;
            dispense_q <= dispense_d;
            if (state_q == S_IDLE && card_rise) begin
                cod_out_q <= bus.cod;
                saldo_q   <= bus.saldo;
                tries_q   <= '0;
            end
            if (state_q == S_ASK_PIN && state_d == S_CHECK)
                pin_q <= bus.key_data;
            if (state_q == S_CHECK && state_d == S_BAD)
                tries_q <= tries_q + 3'd1;
            if (state_q == S_BAD && state_d == S_LOCKED) begin
                lock_q       <= 1'b1;
                locked_cod_q <= cod_out_q;
            end
            if (state_q == S_ASK_VAL && state_d == S_AUTH) begin
                val_q      <= bus.key_data;
                auth_cnt_q <= 1'b0;
            end
            if (state_q == S_AUTH)
                auth_cnt_q <= 1'b1;
            if (state_q == S_DONE && state_d == S_IDLE) begin
                pin_q <= '0;
                val_q <= '0;
            end
        end
    end

    assign bus.en        = en_q;
    assign bus.pin       = pin_q;
    assign bus.cod_out   = cod_out_q;
    assign bus.val       = val_q;
    assign bus.saldo_out = saldo_q;
    assign bus.status    = status_q;
    assign bus.dispense  = dispense_q;

endmodule

// File: tb/tb_mb_pin_sequencer.sv
// tb/tb_mb_pin_sequencer.sv - randomized self-checking bench with a transaction-level outcome model
module tb_mb_pin_sequencer;
    import mb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mb_pin_sequencer_if bus ();

`ifdef MB_TIMEOUT_EN
    mb_pin_sequencer #(.MAX_TRIES(3), .TIMEOUT_CYC(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    mb_pin_sequencer #(.MAX_TRIES(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int errors = 0;
    int checks = 0;

    bit       m_lock = 1'b0;
    int       m_locked_cod = 0;

    function automatic logic [2:0] m_outcome(input int v, input int s);
        return (v <= s) ? ST_OK : ST_NO_FUNDS;
    endfunction

    function automatic logic [2:0] m_first_status(input int c);
        return (m_lock && c == m_locked_cod) ? ST_LOCKED : ST_ASK_PIN;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_status(input logic [2:0] want, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (bus.status === want) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic insert(input int c, input int s);
        bus.cod   = 6'(c);
        bus.saldo = 5'(s);
        bus.card  = 1'b1;
    endtask

    task automatic remove_card();
        bus.card = 1'b0;
        tick(3);
    endtask

    task automatic key(input int d);
        bus.key_vld  = 1'b1;
        bus.key_data = 5'(d);
        tick();
        bus.key_vld  = 1'b0;
        bus.key_data = '0;
    endtask

    task automatic run_txn(input int c, input int s, input int v, input string tag);
        bit ok;
        int en_low, pulses;
        insert(c, s);
        wait_status(ST_ASK_PIN, 6, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s ask_pin: status=%0d want %0d", tag, bus.status, ST_ASK_PIN);
        end
        checks++;
        if (bus.cod_out !== 6'(c) || bus.saldo_out !== 5'(s)) begin
            errors++;
            $display("FAIL %s latch: cod_out=%0d saldo_out=%0d want %0d %0d", tag, bus.cod_out, bus.saldo_out, c, s);
        end
        key(c % 32);
        wait_status(ST_ASK_VAL, 6, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s ask_val: status=%0d want %0d", tag, bus.status, ST_ASK_VAL);
        end
        key(v);
        en_low = 0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.en === 1'b0) en_low++;
            if (bus.dispense === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (en_low != 2) begin
            errors++;
            $display("FAIL %s en_low: got %0d cycles want 2", tag, en_low);
        end
        checks++;
        if (pulses != ((v <= s) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s dispense: got %0d pulses want %0d", tag, pulses, (v <= s) ? 1 : 0);
        end
        checks++;
        if (bus.status !== m_outcome(v, s)) begin
            errors++;
            $display("FAIL %s outcome: status=%0d want %0d", tag, bus.status, m_outcome(v, s));
        end
        checks++;
        if (bus.val !== 5'(v)) begin
            errors++;
            $display("FAIL %s val: got %0d want %0d", tag, bus.val, v);
        end
        remove_card();
        checks++;
        if (bus.status !== ST_IDLE || bus.pin !== 5'd0 || bus.val !== 5'd0) begin
            errors++;
            $display("FAIL %s exit: status=%0d pin=%0d val=%0d want 0 0 0", tag, bus.status, bus.pin, bus.val);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (bus.en !== 1'b1) begin
            errors++;
            $display("FAIL %s en: got %b want 1", tag, bus.en);
        end
        checks++;
        if ({bus.dispense, bus.status, bus.pin, bus.cod_out, bus.val, bus.saldo_out} !== 25'd0) begin
            errors++;
            $display("FAIL %s outputs: disp=%b st=%0d pin=%0d cod=%0d val=%0d saldo=%0d want all 0",
                     tag, bus.dispense, bus.status, bus.pin, bus.cod_out, bus.val, bus.saldo_out);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        check_reset_values("reset");
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_approve();
        int c, s, v;
        run_txn(6, 20, 5, "approve_directed");
        run_txn(13, 17, 17, "approve_equal");
        for (int i = 0; i < 6; i++) begin
            c = $urandom_range(0, 31);
            s = $urandom_range(0, 31);
            v = $urandom_range(1, 31);
            run_txn(c, s, v, "random_txn");
        end
    endtask

    task automatic test_no_funds();
        run_txn(6, 4, 9, "nofunds_directed");
        run_txn(21, 30, 31, "nofunds_by_one");
    endtask

    task automatic test_retry_then_ok();
        bit ok;
        insert(17, 10);
        wait_status(ST_ASK_PIN, 6, ok);
        key(18);
        wait_status(ST_ASK_PIN, 8, ok);
        key(2);
        wait_status(ST_ASK_PIN, 8, ok);
        key(17);
        wait_status(ST_ASK_VAL, 8, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL retry_then_ok: status=%0d want %0d", bus.status, ST_ASK_VAL);
        end
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        remove_card();
    endtask

    task automatic test_lockout();
        bit ok, saw_bad, saw_ask, en_hi;
        int wrong[3] = '{3, 4, 5};
        insert(6, 20);
        wait_status(ST_ASK_PIN, 6, ok);
        en_hi = 1'b1;
        for (int k = 0; k < 3; k++) begin
            key(wrong[k]);
            saw_bad = 1'b0;
            for (int i = 0; i < 6 && !saw_bad; i++) begin
                if (bus.status === ST_BAD_PIN) saw_bad = 1'b1;
                if (bus.en !== 1'b1) en_hi = 1'b0;
                tick();
            end
            checks++;
            if (!saw_bad) begin
                errors++;
                $display("FAIL lock_bad_pin_%0d: status=%0d never showed %0d", k, bus.status, ST_BAD_PIN);
            end
            wait_status((k < 2) ? ST_ASK_PIN : ST_LOCKED, 4, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL lock_after_%0d: status=%0d want %0d", k, bus.status, (k < 2) ? ST_ASK_PIN : ST_LOCKED);
            end
        end
        m_lock = 1'b1;
        m_locked_cod = 6;
        checks++;
        if (!en_hi) begin
            errors++;
            $display("FAIL lock_en: en dropped during PIN entry, want 1");
        end
        remove_card();
        insert(6, 20);
        saw_ask = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            if (bus.status === ST_ASK_PIN) saw_ask = 1'b1;
            if (bus.status === m_first_status(6)) ok = 1'b1;
            tick();
        end
        checks++;
        if (!ok || saw_ask) begin
            errors++;
            $display("FAIL relock: status=%0d asked_pin=%0d want %0d directly", bus.status, saw_ask, m_first_status(6));
        end
        remove_card();
        insert(9, 20);
        wait_status(m_first_status(9), 6, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL other_card: status=%0d want %0d", bus.status, m_first_status(9));
        end
        remove_card();
    endtask

    task automatic test_cancel();
        bit ok, en_hi;
        insert(11, 25);
        wait_status(ST_ASK_PIN, 6, ok);
        key(11);
        wait_status(ST_ASK_VAL, 6, ok);
        key(0);
        tick(3);
        checks++;
        if (bus.status !== ST_ASK_VAL) begin
            errors++;
            $display("FAIL zero_value: status=%0d want %0d", bus.status, ST_ASK_VAL);
        end
        bus.cancel   = 1'b1;
        bus.key_vld  = 1'b1;
        bus.key_data = 5'd7;
        tick();
        bus.cancel   = 1'b0;
        bus.key_vld  = 1'b0;
        bus.key_data = '0;
        en_hi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.en !== 1'b1) en_hi = 1'b0;
            tick();
        end
        checks++;
        if (bus.status !== ST_IDLE) begin
            errors++;
            $display("FAIL cancel_status: got %0d want %0d", bus.status, ST_IDLE);
        end
        checks++;
        if (bus.val !== 5'd0 || !en_hi) begin
            errors++;
            $display("FAIL cancel_val_en: val=%0d en_stayed_high=%0d want 0 1", bus.val, en_hi);
        end
        key(11);
        tick(4);
        checks++;
        if (bus.status !== ST_IDLE || bus.dispense !== 1'b0) begin
            errors++;
            $display("FAIL no_restart: status=%0d dispense=%b want 0 0", bus.status, bus.dispense);
        end
        remove_card();
    endtask

    task automatic test_reset_mid_auth();
        bit ok;
        insert(10, 30);
        wait_status(ST_ASK_PIN, 6, ok);
        key(10);
        wait_status(ST_ASK_VAL, 6, ok);
        key(3);
        checks++;
        if (bus.en !== 1'b0) begin
            errors++;
            $display("FAIL auth_entry: en=%b want 0", bus.en);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        bus.card = 1'b0;
        m_lock = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        insert(6, 20);
        wait_status(m_first_status(6), 6, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lock_cleared: status=%0d want %0d", bus.status, m_first_status(6));
        end
        remove_card();
    endtask

    task automatic test_timeout();
        bit ok;
        insert(12, 8);
        wait_status(ST_ASK_PIN, 6, ok);
`ifdef MB_TIMEOUT_EN
        tick(8);
        checks++;
        if (bus.status !== ST_ASK_PIN) begin
            errors++;
            $display("FAIL timeout_early: status=%0d want %0d", bus.status, ST_ASK_PIN);
        end
        wait_status(ST_IDLE, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout: status=%0d want %0d", bus.status, ST_IDLE);
        end
`else
        tick(100);
        checks++;
        if (bus.status !== ST_ASK_PIN) begin
            errors++;
            $display("FAIL no_timeout: status=%0d want %0d", bus.status, ST_ASK_PIN);
        end
`endif
        remove_card();
    endtask

    initial begin
        bus.card     = 1'b0;
        bus.cod      = '0;
        bus.saldo    = '0;
        bus.key_vld  = 1'b0;
        bus.key_data = '0;
        bus.cancel   = 1'b0;
        test_reset();
        test_approve();
        test_no_funds();
        test_retry_then_ok();
        test_lockout();
        test_cancel();
        test_reset_mid_auth();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
